// File: rtl/capture_readout_pkg.sv
// Shared types for the capture readout engine: FSM states and sample width.
package capture_readout_pkg;

  localparam int SAMPLE_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_READ = 3'd2,
    ST_SEND = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/capture_readout.sv
// Streams captured 4-channel samples out of the circular sample RAM,
// oldest first, packing two samples per byte onto a valid/ready byte link.
module capture_readout
  import capture_readout_pkg::*;
#(
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [15:0]           i_start_addr,
  input  logic [ADDR_WIDTH:0]   i_num_samples,
  output logic [15:0]           o_ram_addr,
  input  logic [SAMPLE_W-1:0]   i_ram_q,
  output logic [2*SAMPLE_W-1:0] o_tx_data,
  output logic                  o_tx_valid,
  input  logic                  i_tx_ready,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int CNT_W = ADDR_WIDTH + 1;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_ptr;
  logic [CNT_W-1:0]        r_remaining;
  logic                    r_flag;
  logic [2*SAMPLE_W-1:0]   r_tx_data;
  logic                    r_tx_valid;
  logic                    r_busy;
  logic                    r_done;

  logic                    w_last_sample;
  logic                    w_unused_addr_hi;

  // Upper start_addr bits are beyond the RAM depth and deliberately ignored.
  assign w_unused_addr_hi = ^i_start_addr[15:ADDR_WIDTH];
  assign w_last_sample    = (r_remaining == CNT_W'(1));

  assign o_ram_addr = {{(16-ADDR_WIDTH){1'b0}}, r_ptr};
  assign o_tx_data  = r_tx_data;
  assign o_tx_valid = r_tx_valid;
  assign o_busy     = r_busy;
  assign o_done     = r_done;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_remaining <= '0;
      r_flag      <= 1'b0;
      r_tx_data   <= '0;
      r_tx_valid  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            if (i_num_samples != '0) begin
              r_ptr       <= i_start_addr[ADDR_WIDTH-1:0];
              r_remaining <= i_num_samples;
              r_flag      <= 1'b0;
              r_busy      <= 1'b1;
              r_state     <= ST_ADDR;
            end else begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end

        // RAM output for r_ptr is valid by the time READ samples it.
        ST_ADDR: begin
          r_state <= ST_READ;
        end

        ST_READ: begin
          if (r_flag) begin
            r_tx_data[2*SAMPLE_W-1:SAMPLE_W] <= i_ram_q;
          end else begin
            r_tx_data <= {{SAMPLE_W{1'b0}}, i_ram_q};
          end
          r_ptr       <= r_ptr + ADDR_WIDTH'(1);
          r_remaining <= r_remaining - CNT_W'(1);
          if (!r_flag && !w_last_sample) begin
            r_flag  <= 1'b1;
            r_state <= ST_ADDR;
          end else begin
            r_tx_valid <= 1'b1;
            r_state    <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (i_tx_ready) begin
            r_tx_valid <= 1'b0;
            r_flag     <= 1'b0;
            if (r_remaining != '0) begin
              r_state <= ST_ADDR;
            end else begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end else begin
            r_state <= ST_SEND;
          end
        end

        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_tx_valid <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_capture_readout.sv
// Directed bench for capture_readout with a registered-address sample RAM model.
module tb_capture_readout;

  localparam int AW    = 13;
  localparam int DEPTH = 1 << AW;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 1'b0;
  logic [15:0] i_start_addr = 16'd0;
  logic [13:0] i_num_samples = 14'd0;
  logic [15:0] o_ram_addr;
  logic [3:0]  i_ram_q;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready = 1'b1;
  logic        o_busy;
  logic        o_done;

  capture_readout #(.ADDR_WIDTH(AW)) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_start       (i_start),
    .i_start_addr  (i_start_addr),
    .i_num_samples (i_num_samples),
    .o_ram_addr    (o_ram_addr),
    .i_ram_q       (i_ram_q),
    .o_tx_data     (o_tx_data),
    .o_tx_valid    (o_tx_valid),
    .i_tx_ready    (i_tx_ready),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  always #5 clk = ~clk;

  // Sample RAM: address registered on the clock, data read asynchronously.
  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] ram_areg = '0;
  always @(posedge clk) ram_areg <= o_ram_addr[AW-1:0];
  assign i_ram_q = mem[ram_areg];

  // Monitors: accepted bytes, done pulses, address transitions, upper address bits.
  logic [7:0]  bytes[$];
  int          done_cnt = 0;
  int          hi_bad = 0;
  int          addr_hits [DEPTH];
  logic [15:0] prev_addr = 16'd0;
  always @(posedge clk) begin
    if (o_tx_valid && i_tx_ready) bytes.push_back(o_tx_data);
    if (o_done) done_cnt <= done_cnt + 1;
    if (o_ram_addr != prev_addr) addr_hits[o_ram_addr[AW-1:0]] <= addr_hits[o_ram_addr[AW-1:0]] + 1;
    prev_addr <= o_ram_addr;
    if (o_ram_addr[15:AW] != 3'b000) hi_bad <= hi_bad + 1;
  end

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic preload(input logic [15:0] sa, input logic [15:0] d);
    for (int j = 0; j < 4; j++) mem[(int'(sa) + j) % DEPTH] = d[4*j +: 4];
  endtask

  task automatic pulse_start(input logic [15:0] sa, input logic [13:0] ns);
    @(posedge clk); #1;
    i_start_addr  = sa;
    i_num_samples = ns;
    i_start       = 1'b1;
    @(posedge clk); #1;
    i_start       = 1'b0;
  endtask

  // Waits for done; lat counts cycles after the start-sampling edge (0 = timeout).
  task automatic wait_done(input int limit, output int lat, output int busy_cyc, output bit fell_with_done);
    bit prev_busy = 1'b0;
    lat = 0; busy_cyc = 0; fell_with_done = 1'b0;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      if (o_busy) busy_cyc++;
      if (o_done) begin
        lat = k;
        fell_with_done = prev_busy && !o_busy;
        break;
      end
      prev_busy = o_busy;
    end
  endtask

  typedef struct {
    logic [15:0] saddr;
    logic [13:0] num;
    logic [15:0] data;
    int          exp_n;
    logic [7:0]  exp_b0;
    logic [7:0]  exp_b1;
    int          exp_lat;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int lat, bcyc, qb, dc0, bad;
    bit fell;
    logic [7:0] d0, expb;
    logic [15:0] a0;
    int base [DEPTH];

    for (int i = 0; i < DEPTH; i++) mem[i] = 4'h0;
    vecs[0] = '{16'd0,    14'd4, 16'h4321, 2, 8'h21, 8'h43, 11};
    vecs[1] = '{16'd8190, 14'd3, 16'h0CBA, 2, 8'hBA, 8'h0C, 9};
    vecs[2] = '{16'd5,    14'd1, 16'h0007, 1, 8'h07, 8'h00, 4};
    vecs[3] = '{16'd8191, 14'd2, 16'h0069, 1, 8'h69, 8'h00, 6};
    vecs[4] = '{16'd200,  14'd0, 16'h0000, 0, 8'h00, 8'h00, 0};
    vecs[5] = '{16'd40,   14'd4, 16'h1E0F, 2, 8'h0F, 8'h1E, 11};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ram_addr", 32'(o_ram_addr), 32'h0);
    chk("reset_tx_data",  32'(o_tx_data),  32'h0);
    chk("reset_outs",     {29'd0, o_tx_valid, o_busy, o_done}, 32'h0);
    @(posedge clk); #1; i_rst = 1'b0;

    // Table-driven runs with tx_ready held high.
    for (int v = 0; v < 6; v++) begin
      preload(vecs[v].saddr, vecs[v].data);
      qb  = bytes.size();
      dc0 = done_cnt;
      pulse_start(vecs[v].saddr, vecs[v].num);
      wait_done(100, lat, bcyc, fell);
      @(negedge clk);
      chk($sformatf("v%0d_done_seen", v), 32'(lat != 0), 32'h1);
      chk($sformatf("v%0d_nbytes", v), 32'(bytes.size() - qb), 32'(vecs[v].exp_n));
      if (vecs[v].exp_n > 0 && bytes.size() > qb)
        chk($sformatf("v%0d_byte0", v), 32'(bytes[qb]), 32'(vecs[v].exp_b0));
      if (vecs[v].exp_n > 1 && bytes.size() > qb + 1)
        chk($sformatf("v%0d_byte1", v), 32'(bytes[qb+1]), 32'(vecs[v].exp_b1));
      chk($sformatf("v%0d_done_once", v), 32'(done_cnt - dc0), 32'h1);
      if (vecs[v].exp_lat != 0) begin
        chk($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
        chk($sformatf("v%0d_busy_falls_with_done", v), 32'(fell), 32'h1);
      end else begin
        chk($sformatf("v%0d_zero_done_early", v), 32'(lat == 1 || lat == 2), 32'h1);
        chk($sformatf("v%0d_zero_no_busy", v), 32'(bcyc), 32'h0);
      end
    end

    // Back-pressure: tx_ready low for 20 cycles during the first SEND.
    preload(16'd0, 16'h4321);
    i_tx_ready = 1'b0;
    qb  = bytes.size();
    pulse_start(16'd0, 14'd4);
    lat = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (o_tx_valid) begin lat = 1; break; end
    end
    chk("stall_valid_seen", 32'(lat), 32'h1);
    d0 = o_tx_data;
    a0 = o_ram_addr;
    chk("stall_first_byte", 32'(d0), 32'h21);
    chk("stall_ptr", 32'(a0), 32'h2);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!o_tx_valid || o_tx_data != d0 || o_ram_addr != a0) bad++;
    end
    chk("stall_hold", 32'(bad), 32'h0);
    i_tx_ready = 1'b1;
    wait_done(100, lat, bcyc, fell);
    @(negedge clk);
    chk("stall_nbytes", 32'(bytes.size() - qb), 32'h2);
    if (bytes.size() >= qb + 2)
      chk("stall_order", {16'd0, bytes[qb], bytes[qb+1]}, 32'h2143);

    // Full-depth dump from address 100 with RAM[i] = i[3:0].
    for (int i = 0; i < DEPTH; i++) mem[i] = 4'(i);
    @(posedge clk); #1; i_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1; i_rst = 1'b0;
    @(posedge clk); @(negedge clk);
    base = addr_hits;
    qb = bytes.size();
    pulse_start(16'd100, 14'd8192);
    wait_done(22000, lat, bcyc, fell);
    @(negedge clk);
    chk("full_done_seen", 32'(lat != 0), 32'h1);
    chk("full_nbytes", 32'(bytes.size() - qb), 32'd4096);
    if (bytes.size() > qb) chk("full_first_byte", 32'(bytes[qb]), 32'h54);
    bad = 0;
    for (int k = 0; k < 4096 && qb + k < bytes.size(); k++) begin
      expb = {mem[(101 + 2*k) % DEPTH], mem[(100 + 2*k) % DEPTH]};
      if (bytes[qb+k] != expb) bad++;
    end
    chk("full_bytes", 32'(bad), 32'h0);
    bad = 0;
    for (int i = 0; i < DEPTH; i++)
      if (addr_hits[i] - base[i] != ((i == 100) ? 2 : 1)) bad++;
    chk("full_addr_once", 32'(bad), 32'h0);

    // Reset during the second READ of a byte, then a fresh 2-sample run.
    preload(16'd0, 16'h4321);
    qb  = bytes.size();
    dc0 = done_cnt;
    pulse_start(16'd0, 14'd4);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_busy_before", 32'(o_busy), 32'h1);
    i_rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("abort_ram_addr", 32'(o_ram_addr), 32'h0);
    chk("abort_tx_data", 32'(o_tx_data), 32'h0);
    chk("abort_outs", {29'd0, o_tx_valid, o_busy, o_done}, 32'h0);
    @(posedge clk); #1; i_rst = 1'b0;
    repeat (3) @(posedge clk);
    chk("abort_no_byte", 32'(bytes.size() - qb), 32'h0);
    chk("abort_no_done", 32'(done_cnt - dc0), 32'h0);
    pulse_start(16'd2, 14'd2);
    wait_done(100, lat, bcyc, fell);
    @(negedge clk);
    chk("rerun_nbytes", 32'(bytes.size() - qb), 32'h1);
    if (bytes.size() > qb) chk("rerun_byte", 32'(bytes[qb]), 32'h43);
    chk("rerun_done_once", 32'(done_cnt - dc0), 32'h1);

    chk("upper_addr_zero", 32'(hi_bad), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/capture_readout.md
Name: capture_readout

Overview:
- Dumps captured logic-analyzer samples out of the 4-channel sample RAM after a capture completes.
- Reads the RAM as a circular buffer, starting at the oldest sample.
- Packs two 4-bit samples per byte and streams the bytes to the host-link transmitter over a valid/ready handshake.
- Sits between the sample RAM read port (address mux selected by busy) and the UART TX byte interface.

Parameters:
- ADDR_WIDTH, 13, RAM address bits actually decoded; buffer depth is 2**ADDR_WIDTH samples.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse: begin readout; sampled only in IDLE
- start_addr  input  16  address of the oldest sample; only [ADDR_WIDTH-1:0] used; latched on start
- num_samples  input  ADDR_WIDTH+1  samples to dump, 0..2**ADDR_WIDTH; latched on start
- ram_addr  output  16  read address to the sample RAM; upper 16-ADDR_WIDTH bits always 0
- ram_q  input  4  RAM read data, bit n = channel n
- tx_data  output  8  packed byte: [3:0] = earlier sample, [7:4] = later sample
- tx_valid  output  1  tx_data is valid
- tx_ready  input  1  transmitter accepts the byte when tx_valid && tx_ready at a rising edge
- busy  output  1  readout in progress; the top level gives ram_addr RAM ownership while busy is high
- done  output  1  one-cycle pulse when the readout completes

Behaviour:
- Reset: state IDLE; ram_addr=0, tx_data=0, tx_valid=0, busy=0, done=0. Internal pointer, remaining count and nibble flag are cleared.
- Reset mid-operation: abort immediately; the next cycle shows the reset values. No partial byte is emitted and no done pulse is produced.
- RAM timing: ram_addr is a registered output. The RAM registers the address, so ram_q for address A is captured by this block 2 cycles after ram_addr takes value A.
- FSM states: IDLE, ADDR, READ, SEND, DONE.
- IDLE:
  - start && num_samples!=0 → latch pointer=start_addr[ADDR_WIDTH-1:0] and remaining=num_samples; set ram_addr=pointer; clear nibble flag; go to ADDR.
  - start && num_samples==0 → go to DONE (no bytes sent).
  - start in any other state is ignored.
- ADDR: hold ram_addr for one cycle, then go to READ.
- READ: capture ram_q into the low nibble (flag=0) or high nibble (flag=1). Then pointer=(pointer+1) mod 2**ADDR_WIDTH, remaining-=1, and drive ram_addr with the new pointer.
  - flag=0 and remaining after decrement !=0 → toggle flag, go to ADDR.
  - flag=1, or remaining reaches 0 → go to SEND. If the count ends on flag=0, the high nibble is forced to 0.
- SEND:
  - tx_valid=1. tx_data is stable and unchanged until the handshake completes.
  - On tx_valid && tx_ready: tx_valid drops next cycle and the flag clears. Go to ADDR if remaining!=0, else DONE.
  - tx_ready may stay low indefinitely; the block holds its state.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- busy is 1 in ADDR, READ and SEND only.
- Address wrap: the pointer wraps from 2**ADDR_WIDTH-1 to 0. num_samples=2**ADDR_WIDTH reads every location exactly once, ending at start_addr-1.
- Throughput with tx_ready tied high: one byte per 5 cycles (ADDR, READ, ADDR, READ, SEND).
- Bytes emitted = ceil(num_samples/2).

Decomposition:
- Shared package holds the FSM state enum (IDLE, ADDR, READ, SEND, DONE) and the sample width constant SAMPLE_W=4.
- ADDR_WIDTH stays a module parameter so it matches the RAM's parameter.
- No sub-module: a single FSM plus datapath registers is the natural split.
- The bench model of the sample RAM lives in the testbench, not in RTL.

Test Plan:
- Preload RAM[0..3]=4'h1,4'h2,4'h3,4'h4; start_addr=0, num_samples=4, tx_ready=1 → bytes 8'h21 then 8'h43; done pulses once, 11 cycles after start; busy falls in the same cycle done rises.
- RAM[8190]=4'hA, RAM[8191]=4'hB, RAM[0]=4'hC; start_addr=16'd8190, num_samples=3 → bytes 8'hBA, 8'h0C; ram_addr sequence 8190, 8191, 0; upper ram_addr bits remain 0.
- num_samples=0 with start → no tx_valid; done pulses the cycle after next; busy never rises.
- tx_ready held low for 20 cycles during the first SEND → tx_valid stays high and tx_data stays stable; the pointer does not advance; the byte order after release is unchanged.
- num_samples=8192 from start_addr=100 with RAM[i]=i[3:0] → 4096 bytes; the first byte is 8'h54; all addresses are read exactly once.
- rst asserted during the second READ of a byte, then start again with num_samples=2 → outputs show reset values the cycle after rst; the aborted byte is never sent; the new run produces exactly 1 byte.
